// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-array bus for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // The master side is everything around the arbiter: requesters plus the array.
  modport master (
    output ld_req, ld_addr, ld_wdata, dm_req, dm_we, dm_addr, dm_wdata,
           if_req, if_addr, mem_rdata,
    input  ld_ack, dm_rdata, dm_ack, if_rdata, if_ack,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  ld_req, ld_addr, ld_wdata, dm_req, dm_we, dm_addr, dm_wdata,
           if_req, if_addr, mem_rdata,
    output ld_ack, dm_rdata, dm_ack, if_rdata, if_ack,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory sequencer shared by loader, data port and fetch
module mem_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int FAIR_MAX = 4
) (
  input logic          clk_i,
  input logic          reset_i,
  mem_arbiter_if.slave bus
);
  localparam int FW = $clog2(FAIR_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_LD, OWN_DM, OWN_IF} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        lat_q, lat_d;
  logic [FW-1:0]     fair_q, fair_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              fair_full;

  assign fair_full = (fair_q == FW'(FAIR_MAX));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    fair_d     = fair_q;
    dm_rdata_d = dm_rdata_q;
    if_rdata_d = if_rdata_q;
    case (state_q)
      S_IDLE: begin
        fair_d = '0;
        // A starved fetch overrides the fixed ld > dm > if order, so the
        // counter never needs to saturate explicitly.
        if (bus.if_req && fair_full) begin
          state_d = S_ISSUE;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
        end else if (bus.ld_req || bus.dm_req) begin
          state_d = S_ISSUE;
          if (bus.if_req) fair_d = fair_q + 1'b1;
          if (bus.ld_req) begin
            owner_d = OWN_LD;
            we_d    = 1'b1;
            addr_d  = bus.ld_addr;
            wdata_d = bus.ld_wdata;
          end else begin
            owner_d = OWN_DM;
            we_d    = bus.dm_we;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
          end
        end else if (bus.if_req) begin
          state_d = S_ISSUE;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          lat_d   = 2'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (lat_q == 2'd0) begin
          state_d = S_DONE;
          if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata;
          else                   dm_rdata_d = bus.mem_rdata;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_LD;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
      fair_q     <= '0;
      dm_rdata_q <= '0;
      if_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      fair_q     <= fair_d;
      dm_rdata_q <= dm_rdata_d;
      if_rdata_q <= if_rdata_d;
    end
  end

  assign bus.mem_en    = (state_q == S_ISSUE);
  assign bus.mem_we    = bus.mem_en & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.ld_ack    = (state_q == S_DONE) && (owner_q == OWN_LD);
  assign bus.dm_ack    = (state_q == S_DONE) && (owner_q == OWN_DM);
  assign bus.if_ack    = (state_q == S_DONE) && (owner_q == OWN_IF);
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at RD_LAT 1 and 3
module tb_mem_arbiter;
  localparam int P_LD = 0;
  localparam int P_DM = 1;
  localparam int P_IF = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   en_cnt1 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b1 ();
  mem_arbiter_if #(.ADDR_W(7), .DATA_W(8)) b3 ();

  mem_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1), .FAIR_MAX(4)) u1 (
    .clk_i(clk), .reset_i(reset), .bus(b1));
  mem_arbiter #(.ADDR_W(7), .DATA_W(8), .RD_LAT(3), .FAIR_MAX(4)) u3 (
    .clk_i(clk), .reset_i(reset), .bus(b3));

  // Array models: read data is only meaningful exactly RD_LAT cycles after mem_en.
  logic [7:0] mem1 [0:127];
  logic [7:0] mem3 [0:127];
  logic [7:0] pipe1 [0:2];
  logic [7:0] pipe3 [0:2];

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
    pipe1[0] <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr] : 8'hEE;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
    pipe3[0] <= (b3.mem_en && !b3.mem_we) ? mem3[b3.mem_addr] : 8'hEE;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b1.mem_rdata = pipe1[0];
  assign b3.mem_rdata = pipe3[2];

  typedef struct {
    int         dut;
    int         port;
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  task automatic expect_ack(input int d, input int p, input logic [7:0] data, input int due);
    exp_t e;
    e.dut = d; e.port = p; e.data = data; e.due = due;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input int d, input int p, input logic [7:0] data);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: dut%0d port%0d acked at cycle %0d, required no ack", d, p, cyc);
    end else begin
      e = sb.pop_front();
      if (e.dut != d || e.port != p || e.due != cyc || (p != P_LD && data !== e.data)) begin
        n_err++;
        $display("FAIL sb_ack: got dut%0d port%0d data %02h cycle %0d, required dut%0d port%0d data %02h cycle %0d",
                 d, p, data, cyc, e.dut, e.port, e.data, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (b1.mem_en) en_cnt1 <= en_cnt1 + 1;
    if (b1.ld_ack) sb_pop(1, P_LD, 8'h00);
    if (b1.dm_ack) sb_pop(1, P_DM, b1.dm_rdata);
    if (b1.if_ack) sb_pop(1, P_IF, b1.if_rdata);
    if (b3.ld_ack) sb_pop(3, P_LD, 8'h00);
    if (b3.dm_ack) sb_pop(3, P_DM, b3.dm_rdata);
    if (b3.if_ack) sb_pop(3, P_IF, b3.if_rdata);
  end

  task automatic set_req(input int d, input int p, input logic v, input logic we,
                         input logic [6:0] a, input logic [7:0] wd);
    if (d == 1) begin
      case (p)
        P_LD:    begin b1.ld_req = v; b1.ld_addr = a; b1.ld_wdata = wd; end
        P_DM:    begin b1.dm_req = v; b1.dm_we = we; b1.dm_addr = a; b1.dm_wdata = wd; end
        default: begin b1.if_req = v; b1.if_addr = a; end
      endcase
    end else begin
      case (p)
        P_LD:    begin b3.ld_req = v; b3.ld_addr = a; b3.ld_wdata = wd; end
        P_DM:    begin b3.dm_req = v; b3.dm_we = we; b3.dm_addr = a; b3.dm_wdata = wd; end
        default: begin b3.if_req = v; b3.if_addr = a; end
      endcase
    end
  endtask

  function automatic logic ack_of(input int d, input int p);
    if (d == 1) return (p == P_LD) ? b1.ld_ack : (p == P_DM) ? b1.dm_ack : b1.if_ack;
    return (p == P_LD) ? b3.ld_ack : (p == P_DM) ? b3.dm_ack : b3.if_ack;
  endfunction

  // Requester: raise req at a negedge, hold until ack, drop before the edge ending the ack cycle.
  task automatic req(input int d, input int p, input logic we, input logic [6:0] a, input logic [7:0] wd);
    int t;
    set_req(d, p, 1'b1, we, a, wd);
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ack_of(d, p)) break;
    end
    if (t == 50) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_dut%0d_port%0d: no ack within 50 cycles, required ack", d, p);
    end
    set_req(d, p, 1'b0, we, a, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;
    reset = 1'b1;
    set_req(1, P_LD, 1'b0, 1'b0, 7'h0, 8'h0);
    set_req(1, P_DM, 1'b0, 1'b0, 7'h0, 8'h0);
    set_req(1, P_IF, 1'b0, 1'b0, 7'h0, 8'h0);
    set_req(3, P_LD, 1'b0, 1'b0, 7'h0, 8'h0);
    set_req(3, P_DM, 1'b0, 1'b0, 7'h0, 8'h0);
    set_req(3, P_IF, 1'b0, 1'b0, 7'h0, 8'h0);
    repeat (3) @(negedge clk);

    chk("rst_busy", b1.busy, 0);
    chk("rst_acks", {b1.ld_ack, b1.dm_ack, b1.if_ack}, 0);
    chk("rst_mem_en_we", {b1.mem_en, b1.mem_we}, 0);
    chk("rst_mem_addr", b1.mem_addr, 0);
    chk("rst_mem_wdata", b1.mem_wdata, 0);
    chk("rst_rdata", {b1.dm_rdata, b1.if_rdata}, 0);
    chk("rst_fair", u1.fair_q, 0);
    chk("rst3_busy", b3.busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // Preload through the loader port: writes ack 2 cycles after sampling.
    n = cyc; expect_ack(1, P_LD, 8'h00, n + 2); req(1, P_LD, 1'b1, 7'h05, 8'hA3); @(negedge clk);
    n = cyc; expect_ack(1, P_LD, 8'h00, n + 2); req(1, P_LD, 1'b1, 7'h07, 8'h3C); @(negedge clk);
    chk("ld_mem5", mem1[5], 8'hA3);

    // Single fetch: mem_en the cycle after sampling, ack two cycles later.
    n = cyc;
    expect_ack(1, P_IF, 8'hA3, n + 3);
    fork
      req(1, P_IF, 1'b0, 7'h05, 8'h00);
      begin
        @(negedge clk);
        chk("fetch_mem_en", b1.mem_en, 1);
        chk("fetch_mem_we", b1.mem_we, 0);
        chk("fetch_mem_addr", b1.mem_addr, 7'h05);
        chk("fetch_busy", b1.busy, 1);
      end
    join
    @(negedge clk);

    // Store then load through the data port; a store leaves dm_rdata untouched.
    n = cyc; expect_ack(1, P_DM, 8'h00, n + 2); req(1, P_DM, 1'b1, 7'h10, 8'h5C); @(negedge clk);
    chk("st_mem10", mem1[7'h10], 8'h5C);
    n = cyc; expect_ack(1, P_DM, 8'h5C, n + 3); req(1, P_DM, 1'b0, 7'h10, 8'h00); @(negedge clk);

    // All three at once: ld, then dm read, then fetch; one IDLE cycle between grants.
    n = cyc;
    e0 = en_cnt1;
    expect_ack(1, P_LD, 8'h00, n + 2);
    expect_ack(1, P_DM, 8'h5C, n + 6);
    expect_ack(1, P_IF, 8'hA3, n + 10);
    fork
      req(1, P_LD, 1'b1, 7'h20, 8'h11);
      req(1, P_DM, 1'b0, 7'h10, 8'h00);
      req(1, P_IF, 1'b0, 7'h05, 8'h00);
    join
    @(negedge clk);
    chk("simul_mem_en_count", en_cnt1 - e0, 3);
    chk("simul_mem20", mem1[7'h20], 8'h11);

    // Fetch held against back-to-back dm loads: fetch wins after 4 dm grants.
    n = cyc;
    for (int i = 0; i < 4; i++) expect_ack(1, P_DM, 8'h5C, n + 3 + 4 * i);
    expect_ack(1, P_IF, 8'h3C, n + 19);
    expect_ack(1, P_DM, 8'h5C, n + 23);
    fork
      req(1, P_IF, 1'b0, 7'h07, 8'h00);
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        req(1, P_DM, 1'b0, 7'h10, 8'h00);
      end
      begin
        repeat (15) @(negedge clk);
        chk("fair_saturated", u1.fair_q, 4);
      end
    join
    @(negedge clk);
    chk("fair_cleared", u1.fair_q, 0);

    // Reset while a fetch is in WAIT: no ack, everything back to reset values.
    set_req(1, P_IF, 1'b1, 1'b0, 7'h05, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("wait_busy", b1.busy, 1);
    reset = 1'b1;
    set_req(1, P_IF, 1'b0, 1'b0, 7'h05, 8'h00);
    @(negedge clk);
    chk("rstw_busy", b1.busy, 0);
    chk("rstw_acks", {b1.ld_ack, b1.dm_ack, b1.if_ack}, 0);
    chk("rstw_mem_en_we", {b1.mem_en, b1.mem_we}, 0);
    chk("rstw_mem_addr", b1.mem_addr, 0);
    chk("rstw_rdata", {b1.dm_rdata, b1.if_rdata}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // RD_LAT=3 instance: reads ack 5 cycles after sampling.
    n = cyc; expect_ack(3, P_LD, 8'h00, n + 2); req(3, P_LD, 1'b1, 7'h42, 8'h9D); @(negedge clk);
    n = cyc; expect_ack(3, P_LD, 8'h00, n + 2); req(3, P_LD, 1'b1, 7'h30, 8'h77); @(negedge clk);
    n = cyc; expect_ack(3, P_IF, 8'h9D, n + 5); req(3, P_IF, 1'b0, 7'h42, 8'h00); @(negedge clk);
    n = cyc; expect_ack(3, P_DM, 8'h77, n + 5); req(3, P_DM, 1'b0, 7'h30, 8'h00); @(negedge clk);
    chk("lat3_if_held", b3.if_rdata, 8'h9D);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
